// File: rtl/score_bank_v1.sv
// score_bank_v1: 2*MODULES Smith-Waterman (affine gap) scoring slots sharing one query and penalty set.
// Each busy slot scores one target base per clock; finished slots publish {ID, score} and feed a running best.
module score_bank_v1 #(
    parameter int SCORE_WIDTH   = 12,
    parameter int ID_WIDTH      = 48,
    parameter int LEN_WIDTH     = 12,
    parameter int TARGET_LENGTH = 128,
    parameter int MODULES       = 2,
    parameter int MODULE_LENGTH = 128,
    parameter int ZERO          = 2048,
    parameter int IN_WIDTH      = 2 + ID_WIDTH + LEN_WIDTH + 2 * TARGET_LENGTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ld_sequence,
    input  logic                             ld_penalties,
    input  logic [IN_WIDTH-1:0]              data_in,
    input  logic [4*SCORE_WIDTH-1:0]         penalties,
    output logic                             ready,
    output logic                             full,
    output logic [2*MODULES*SCORE_WIDTH-1:0] results,
    output logic [2*MODULES*ID_WIDTH-1:0]    IDs,
    output logic [2*MODULES-1:0]             vld,
    output logic [ID_WIDTH+SCORE_WIDTH-1:0]  max,
    output logic                             vld_max,
    output logic [4*MODULES-1:0]             o_slot_state
);
    localparam int NS = 2 * MODULES;
    localparam int SW = SCORE_WIDTH;
    localparam int ML = MODULE_LENGTH;
    localparam int TW = 2 * TARGET_LENGTH;
    localparam logic [SW-1:0]        ZB   = SW'(ZERO);
    localparam logic [LEN_WIDTH-1:0] ML_L = LEN_WIDTH'(MODULE_LENGTH);
    localparam logic [LEN_WIDTH-1:0] TL_L = LEN_WIDTH'(TARGET_LENGTH);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} slot_state_t;

    function automatic logic [SW-1:0] sat_add(input logic [SW-1:0] a, input logic [SW-1:0] p);
        logic [SW+1:0] sum;
        sum = {2'b00, a} + {{2{p[SW-1]}}, p};
        if (sum[SW+1])   return '0;
        else if (sum[SW]) return '1;
        else              return sum[SW-1:0];
    endfunction

    function automatic logic [SW-1:0] mx(input logic [SW-1:0] a, input logic [SW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // data_in is MSB-first: type, ID, length, then base 0 in the top two bits of the sequence field
    logic [1:0]           w_type;
    logic [ID_WIDTH-1:0]  w_id;
    logic [LEN_WIDTH-1:0] w_len;
    logic [TW-1:0]        w_seq;
    logic [TW+2*ML-1:0]   w_qcat;
    assign w_type = data_in[IN_WIDTH-1 -: 2];
    assign w_id   = data_in[IN_WIDTH-3 -: ID_WIDTH];
    assign w_len  = data_in[IN_WIDTH-3-ID_WIDTH -: LEN_WIDTH];
    assign w_seq  = data_in[TW-1:0];
    assign w_qcat = {w_seq, {(2*ML){1'b0}}};

    logic [4*SW-1:0]      r_pen;
    logic                 r_pen_ok, r_qry_ok;
    logic [1:0]           r_qry [ML];
    logic [LEN_WIDTH-1:0] r_qlen;
    logic [SW-1:0]        w_match, w_mism, w_gopen, w_gext;
    assign w_match = r_pen[4*SW-1 -: SW];
    assign w_mism  = r_pen[3*SW-1 -: SW];
    assign w_gopen = r_pen[2*SW-1 -: SW];
    assign w_gext  = r_pen[SW-1:0];

    slot_state_t          r_state [NS];
    slot_state_t          w_state_nxt [NS];
    logic [ID_WIDTH-1:0]  r_id [NS], r_oid [NS];
    logic [LEN_WIDTH-1:0] r_len [NS], r_col [NS];
    logic [TW-1:0]        r_tgt [NS];
    logic [SW-1:0]        r_h [NS][ML], r_e [NS][ML], w_h [NS][ML], w_e [NS][ML];
    logic [SW-1:0]        r_best [NS], w_best [NS], r_res [NS];
    logic [NS-1:0]        w_free, w_step, w_finish, w_load;
    logic                 w_any_busy, w_qry_acc, w_tgt_acc;
    logic [ID_WIDTH-1:0]  r_max_id, w_max_id;
    logic [SW-1:0]        r_max_sc, w_max_sc;
    logic                 r_max_vld, w_max_vld;

    // Slot FSM, process 1: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < NS; s++) r_state[s] <= S_IDLE;
        end else begin
            for (int s = 0; s < NS; s++) r_state[s] <= w_state_nxt[s];
        end
    end

    // Slot FSM, process 2: next state
    always_comb begin
        for (int s = 0; s < NS; s++) begin
            w_state_nxt[s] = r_state[s];
            if (w_load[s])        w_state_nxt[s] = S_BUSY;
            else if (w_finish[s]) w_state_nxt[s] = S_DONE;
        end
    end

    // Slot FSM, process 3: decoded outputs; a finishing slot is still busy, so it cannot be reloaded this edge
    always_comb begin
        w_free     = '0;
        w_step     = '0;
        w_finish   = '0;
        w_any_busy = 1'b0;
        for (int s = 0; s < NS; s++) begin
            w_free[s]   = (r_state[s] != S_BUSY);
            w_step[s]   = (r_state[s] == S_BUSY) && (r_col[s] != r_len[s]);
            w_finish[s] = (r_state[s] == S_BUSY) && (r_col[s] == r_len[s]);
            w_any_busy  = w_any_busy | (r_state[s] == S_BUSY);
        end
    end

    assign ready     = r_pen_ok & r_qry_ok;
    assign full      = ~|w_free;
    assign w_qry_acc = ld_sequence && (w_type == 2'b01) && !w_any_busy;
    assign w_tgt_acc = ld_sequence && (w_type == 2'b10) && ready && !full;

    always_comb begin
        logic v_found;
        v_found = 1'b0;
        w_load  = '0;
        for (int s = 0; s < NS; s++) begin
            if (w_tgt_acc && w_free[s] && !v_found) begin
                w_load[s] = 1'b1;
                v_found   = 1'b1;
            end
        end
    end

    // One DP column per busy slot; F ripples down the query rows within the cycle
    always_comb begin
        logic [TW-1:0] v_tsh;
        logic [1:0]    v_tb;
        logic [SW-1:0] v_diag, v_hup, v_fup, v_f, v_sub, v_best;
        v_tsh  = '0;
        v_tb   = '0;
        v_diag = ZB;
        v_hup  = ZB;
        v_fup  = '0;
        v_f    = '0;
        v_sub  = '0;
        v_best = ZB;
        w_h    = '{default: '0};
        w_e    = '{default: '0};
        w_best = '{default: '0};
        for (int s = 0; s < NS; s++) begin
            v_tsh  = r_tgt[s] << {r_col[s], 1'b0};
            v_tb   = v_tsh[TW-1 -: 2];
            v_diag = ZB;
            v_hup  = ZB;
            v_fup  = '0;
            v_best = r_best[s];
            for (int i = 0; i < ML; i++) begin
                v_sub     = (r_qry[i] == v_tb) ? w_match : w_mism;
                w_e[s][i] = mx(sat_add(r_h[s][i], w_gopen), sat_add(r_e[s][i], w_gext));
                v_f       = mx(sat_add(v_hup, w_gopen), sat_add(v_fup, w_gext));
                w_h[s][i] = mx(mx(ZB, sat_add(v_diag, v_sub)), mx(w_e[s][i], v_f));
                if (LEN_WIDTH'(i) < r_qlen) v_best = mx(v_best, w_h[s][i]);
                v_diag = r_h[s][i];
                v_hup  = w_h[s][i];
                v_fup  = v_f;
            end
            w_best[s] = v_best;
        end
    end

    // Datapath state is qualified by the slot FSM, so it carries no reset
    always_ff @(posedge clk) begin
        if (ld_penalties) r_pen <= penalties;
        if (w_qry_acc) begin
            r_qlen <= (w_len > ML_L) ? ML_L : w_len;
            for (int i = 0; i < ML; i++) r_qry[i] <= w_qcat[TW+2*ML-1-2*i -: 2];
        end
        for (int s = 0; s < NS; s++) begin
            if (w_load[s]) begin
                r_id[s]   <= w_id;
                r_len[s]  <= (w_len > TL_L) ? TL_L : w_len;
                r_tgt[s]  <= w_seq;
                r_col[s]  <= '0;
                r_best[s] <= ZB;
                for (int i = 0; i < ML; i++) begin
                    r_h[s][i] <= ZB;
                    r_e[s][i] <= '0;
                end
            end else if (w_step[s]) begin
                r_col[s]  <= r_col[s] + LEN_WIDTH'(1);
                r_best[s] <= w_best[s];
                for (int i = 0; i < ML; i++) begin
                    r_h[s][i] <= w_h[s][i];
                    r_e[s][i] <= w_e[s][i];
                end
            end
        end
    end

    // Strictly-greater update in slot order: ties keep the incumbent, then the lowest index
    always_comb begin
        w_max_vld = r_max_vld;
        w_max_id  = r_max_id;
        w_max_sc  = r_max_sc;
        for (int s = 0; s < NS; s++) begin
            if (w_finish[s] && (!w_max_vld || (r_best[s] > w_max_sc))) begin
                w_max_vld = 1'b1;
                w_max_id  = r_id[s];
                w_max_sc  = r_best[s];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pen_ok  <= 1'b0;
            r_qry_ok  <= 1'b0;
            r_max_vld <= 1'b0;
            r_max_id  <= '0;
            r_max_sc  <= '0;
            for (int s = 0; s < NS; s++) begin
                r_res[s] <= '0;
                r_oid[s] <= '0;
            end
        end else begin
            if (ld_penalties) r_pen_ok <= 1'b1;
            if (w_qry_acc) begin
                r_qry_ok  <= 1'b1;
                r_max_vld <= 1'b0;
                r_max_id  <= '0;
                r_max_sc  <= '0;
            end else begin
                r_max_vld <= w_max_vld;
                r_max_id  <= w_max_id;
                r_max_sc  <= w_max_sc;
            end
            for (int s = 0; s < NS; s++) begin
                if (w_finish[s]) begin
                    r_res[s] <= r_best[s];
                    r_oid[s] <= r_id[s];
                end
            end
        end
    end

    // Slot 0 sits at the MSB end of every per-slot bus
    always_comb begin
        results      = '0;
        IDs          = '0;
        vld          = '0;
        o_slot_state = '0;
        for (int s = 0; s < NS; s++) begin
            results[(NS-1-s)*SW +: SW]          = r_res[s];
            IDs[(NS-1-s)*ID_WIDTH +: ID_WIDTH]  = r_oid[s];
            vld[NS-1-s]                         = (r_state[s] == S_DONE);
            o_slot_state[2*(NS-1-s) +: 2]       = r_state[s];
        end
    end

    assign max     = {r_max_id, r_max_sc};
    assign vld_max = r_max_vld;

endmodule

// File: tb/tb_score_bank_v1.sv
// Directed bench for score_bank_v1: hand-scored alignments, slot allocation, max tracking and reset.
`timescale 1ns/1ps
module tb_score_bank_v1;
    localparam int SW   = 12;
    localparam int IW   = 48;
    localparam int LW   = 12;
    localparam int TL   = 128;
    localparam int NS   = 4;
    localparam int IN_W = 2 + IW + LW + 2 * TL;
    localparam logic [1:0] T_QRY = 2'b01;
    localparam logic [1:0] T_TGT = 2'b10;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             ld_sequence = 1'b0;
    logic             ld_penalties = 1'b0;
    logic [IN_W-1:0]  data_in = '0;
    logic [4*SW-1:0]  penalties = '0;
    logic             ready, full, vld_max;
    logic [NS*SW-1:0] results;
    logic [NS*IW-1:0] IDs;
    logic [NS-1:0]    vld;
    logic [IW+SW-1:0] max;
    logic [2*NS-1:0]  slot_state;

    score_bank_v1 dut (
        .clk          (clk),
        .rst          (rst),
        .ld_sequence  (ld_sequence),
        .ld_penalties (ld_penalties),
        .data_in      (data_in),
        .penalties    (penalties),
        .ready        (ready),
        .full         (full),
        .results      (results),
        .IDs          (IDs),
        .vld          (vld),
        .max          (max),
        .vld_max      (vld_max),
        .o_slot_state (slot_state)
    );

    // scoreboard
    int n_checks = 0;
    int n_pass   = 0;
    logic [IW+SW-1:0] exp_q[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [SW-1:0] slot_res(input int s);
        return results[(NS-1-s)*SW +: SW];
    endfunction

    function automatic logic [IW-1:0] slot_id(input int s);
        return IDs[(NS-1-s)*IW +: IW];
    endfunction

    function automatic logic slot_vld(input int s);
        return vld[NS-1-s];
    endfunction

    function automatic logic [IN_W-1:0] make_rec(input logic [1:0] typ, input logic [IW-1:0] id,
                                                 input string seq);
        logic [IN_W-1:0] r;
        logic [1:0]      code;
        r = '0;
        r[IN_W-1 -: 2]     = typ;
        r[IN_W-3 -: IW]    = id;
        r[IN_W-3-IW -: LW] = LW'(seq.len());
        for (int k = 0; k < seq.len(); k++) begin
            case (seq[k])
                "A":     code = 2'b10;
                "G":     code = 2'b11;
                "T":     code = 2'b00;
                default: code = 2'b01;
            endcase
            r[2*TL-1-2*k -: 2] = code;
        end
        return r;
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [IN_W-1:0] rec);
        data_in     = rec;
        ld_sequence = 1'b1;
        tick();
        ld_sequence = 1'b0;
    endtask

    task automatic load_pen(input logic [SW-1:0] m, input logic [SW-1:0] mm,
                            input logic [SW-1:0] go, input logic [SW-1:0] ge);
        penalties    = {m, mm, go, ge};
        ld_penalties = 1'b1;
        tick();
        ld_penalties = 1'b0;
    endtask

    task automatic wait_done(input int s, input int budget, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!slot_vld(s) && cyc < budget);
    endtask

    int cyc;
    logic [IW+SW-1:0] exp_rec;

    initial begin
        // reset state
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_ready", ready, 0);
        check_val("rst_full", full, 0);
        check_val("rst_vld", vld, 0);
        check_val("rst_vld_max", vld_max, 0);
        check_val("rst_max", max, 0);
        check_val("rst_results", results, 0);
        @(negedge clk) rst = 1'b1;
        tick();

        // basic alignment ACGT vs ACGT
        load_pen(12'd5, -12'sd4, -12'sd12, -12'sd4);
        check_val("ready_pen_only", ready, 0);
        send(make_rec(T_QRY, 48'd0, "ACGT"));
        check_val("ready_after_query", ready, 1);
        send(make_rec(T_TGT, 48'd0, "ACGT"));
        wait_done(0, 20, cyc);
        check_val("lat_acgt", cyc, 5);
        check_val("res_acgt", slot_res(0), 2068);
        check_val("id_acgt", slot_id(0), 0);
        check_val("max_acgt", max, {48'd0, 12'd2068});
        check_val("vld_max_acgt", vld_max, 1);

        // all-mismatch and zero-length targets
        send(make_rec(T_QRY, 48'd0, "AAAA"));
        check_val("qry_clears_vld_max", vld_max, 0);
        check_val("qry_clears_max", max, 0);
        send(make_rec(T_TGT, 48'd5, "TTTT"));
        check_val("reload_clears_vld", slot_vld(0), 0);
        wait_done(0, 20, cyc);
        check_val("lat_tttt", cyc, 5);
        check_val("res_tttt", slot_res(0), 2048);
        check_val("max_floor", max, {48'd5, 12'd2048});
        send(make_rec(T_TGT, 48'd6, ""));
        wait_done(0, 20, cyc);
        check_val("lat_len0", cyc, 1);
        check_val("res_len0", slot_res(0), 2048);
        check_val("id_len0", slot_id(0), 6);

        // single gap open inside the alignment
        send(make_rec(T_QRY, 48'd0, "ACGTACGT"));
        send(make_rec(T_TGT, 48'd7, "ACGACGT"));
        wait_done(0, 20, cyc);
        check_val("lat_gap", cyc, 8);
        check_val("res_gap", slot_res(0), 2071);
        check_val("max_gap", max, {48'd7, 12'd2071});

        // fill all slots, drop the fifth, ignore a query while busy
        send(make_rec(T_QRY, 48'd0, "ACGTACGT"));
        exp_q.push_back({48'd11, 12'd2088});
        exp_q.push_back({48'd12, 12'd2053});
        exp_q.push_back({48'd13, 12'd2053});
        exp_q.push_back({48'd14, 12'd2073});
        send(make_rec(T_TGT, 48'd11, "ACGTACGT"));
        send(make_rec(T_TGT, 48'd12, "TTTTTTTT"));
        send(make_rec(T_TGT, 48'd13, "AAAAAAAA"));
        check_val("full_three", full, 0);
        send(make_rec(T_TGT, 48'd14, "ACGTAAAA"));
        check_val("full_four", full, 1);
        send(make_rec(T_TGT, 48'd99, "ACGTACGT"));
        check_val("full_dropped", full, 1);
        send(make_rec(T_QRY, 48'd0, "AAAA"));
        repeat (3) tick();
        check_val("full_before_done", full, 1);
        check_val("vld0_before_done", slot_vld(0), 0);
        tick();
        check_val("full_after_done", full, 0);
        check_val("vld0_after_done", slot_vld(0), 1);
        repeat (3) tick();
        for (int s = 0; s < NS; s++) begin
            exp_rec = exp_q.pop_front();
            check_val($sformatf("slot%0d_rec", s), {slot_id(s), slot_res(s)}, exp_rec);
        end
        check_val("max_fill", max, {48'd11, 12'd2088});
        send(make_rec(T_TGT, 48'd20, "AAAA"));
        check_val("reload_vld0", slot_vld(0), 0);
        check_val("reload_vld1", slot_vld(1), 1);
        wait_done(0, 20, cyc);
        check_val("res_reload", slot_res(0), 2053);

        // max tracking with a later tie
        send(make_rec(T_QRY, 48'd0, "ACGT"));
        send(make_rec(T_TGT, 48'd1, "AC"));
        wait_done(0, 20, cyc);
        check_val("max_id1", max, {48'd1, 12'd2058});
        send(make_rec(T_TGT, 48'd2, "ACGT"));
        wait_done(0, 20, cyc);
        check_val("max_id2", max, {48'd2, 12'd2068});
        send(make_rec(T_TGT, 48'd3, "ACGT"));
        wait_done(0, 20, cyc);
        check_val("res_id3", slot_res(0), 2068);
        check_val("max_tie_keeps", max, {48'd2, 12'd2068});
        send(make_rec(T_QRY, 48'd0, "AAAA"));
        check_val("max_cleared_vld", vld_max, 0);
        check_val("max_cleared", max, 0);

        // two slots finishing on one edge with equal scores
        send(make_rec(T_QRY, 48'd0, "ACGT"));
        send(make_rec(T_TGT, 48'd30, "GTA"));
        send(make_rec(T_TGT, 48'd31, "AC"));
        repeat (2) tick();
        check_val("tie_not_yet", vld_max, 0);
        tick();
        check_val("tie_vld", {slot_vld(0), slot_vld(1)}, 2'b11);
        check_val("tie_low_index", max, {48'd30, 12'd2058});

        // asynchronous reset mid-computation
        send(make_rec(T_TGT, 48'd40, "ACGTACGT"));
        repeat (2) tick();
        #2 rst = 1'b0;
        #1;
        check_val("arst_vld", vld, 0);
        check_val("arst_results", results, 0);
        check_val("arst_ids", IDs, 0);
        check_val("arst_max", {vld_max, max}, 0);
        check_val("arst_ready_full", {ready, full}, 0);
        check_val("arst_state", slot_state, 0);
        @(negedge clk) rst = 1'b1;
        tick();
        check_val("post_rst_ready", ready, 0);
        send(make_rec(T_TGT, 48'd41, "ACGT"));
        repeat (6) tick();
        check_val("post_rst_dropped", {vld, slot_state}, 0);
        load_pen(12'd5, -12'sd4, -12'sd12, -12'sd4);
        check_val("post_rst_pen_only", ready, 0);
        send(make_rec(T_QRY, 48'd0, "ACGT"));
        check_val("post_rst_ready_again", ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/score_bank_v1.md
Name: score_bank_v1

Overview:
- Bank of 2*MODULES Smith-Waterman scoring slots sharing one query, one penalty set, one load port.
- Each slot takes one target DNA sequence and computes its local-alignment score against the query (affine gaps).
- Per-slot results are published with the target ID, and the running best {ID, score} is tracked.
- Sits between the sequence feeder and the host result collector.

Parameters:
- SCORE_WIDTH, 12: score and penalty width in bits.
- ID_WIDTH, 48: sequence ID field width.
- LEN_WIDTH, 12: sequence length field width.
- TARGET_LENGTH, 128: maximum bases in the data_in sequence field.
- MODULES, 2: scoring modules; each owns 2 slots, so there are 2*MODULES slots.
- MODULE_LENGTH, 128: maximum query bases (DP column depth).
- ZERO, 2048: score bias. The external score value equals the output minus ZERO.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- ld_sequence, input, 1: load the record on data_in.
- ld_penalties, input, 1: latch penalties.
- data_in, input, IN_WIDTH = 2+ID_WIDTH+LEN_WIDTH+2*TARGET_LENGTH: record, indexed MSB-first (bit 0 = MSB).
  - [0:1] type: 01 = query, 10 = target, others ignored.
  - [2 +: ID_WIDTH] ID.
  - next LEN_WIDTH bits: length in bases.
  - remainder: sequence, base k at bits [2k:2k+1]; A=10, G=11, T=00, C=01.
- penalties, input, 4*SCORE_WIDTH: {match, mismatch, gap_open, gap_extend}, match at MSB, each two's complement.
- ready, output, 1: penalties and query both loaded.
- full, output, 1: all slots busy.
- results, output, 2*MODULES*SCORE_WIDTH: slot s at [s*SCORE_WIDTH +: SCORE_WIDTH], slot 0 at MSB end, biased.
- IDs, output, 2*MODULES*ID_WIDTH: ID of each slot's target, same ordering.
- vld, output, 2*MODULES: vld[s] (bit 0 = MSB) means slot s holds a finished result.
- max, output, ID_WIDTH+SCORE_WIDTH: {ID, biased score} of best result since the last query load.
- vld_max, output, 1: max is valid.

Behaviour:
- Reset (rst=0, async):
  - All outputs 0.
  - Penalty-loaded and query-loaded flags cleared.
  - All slots idle; any in-flight computation is discarded.
- ld_penalties: the penalties input is latched at the clock edge.
- Query record (type 01, ld_sequence=1):
  - Accepted only when no slot is busy; otherwise ignored.
  - Stores the query and its length, clipped to MODULE_LENGTH.
  - Clears vld_max and max.
  - ready becomes 1 on the next edge if penalties are loaded.
- Target record (type 10, ld_sequence=1):
  - Accepted only if ready=1 and full=0; otherwise dropped silently.
  - Goes to the lowest-index free slot. A slot is free if it is idle or holds a finished result.
  - Loading clears that slot's vld and latches ID and length, with length clipped to TARGET_LENGTH.
- full is combinational from slot state: 1 when no slot is free.
- Timing, for a target accepted at edge t with length L:
  - Base j (1..L) is processed at edge t+j.
  - At edge t+L+1 the slot writes results/IDs, asserts vld, and becomes free.
  - vld stays high until the slot is reloaded or reset.
  - L=0 gives result ZERO at edge t+1.
- DP per slot, query index i, one target column j per cycle, scores held biased:
  - Floor is ZERO.
  - s = match if bases are equal, else mismatch.
  - E(i,j) = max(H(i,j-1)+gap_open, E(i,j-1)+gap_extend).
  - F(i,j) = max(H(i-1,j)+gap_open, F(i-1,j)+gap_extend), computed combinationally down the column.
  - H(i,j) = max(ZERO, H(i-1,j-1)+s, E(i,j), F(i,j)).
  - Boundaries: H = ZERO, E and F = 0.
  - Result is the maximum H over all cells.
  - Additions saturate at 2^SCORE_WIDTH-1 and at 0.
- Max tracking:
  - When a result completes with score strictly greater than max's score (or vld_max=0), max and vld_max update on the same edge as vld.
  - Ties keep the earlier result.
  - If several slots finish on the same edge, the lowest index wins ties.
- A target load and a slot completion may occur on the same edge. The completing slot is not reusable until the following edge.

Test Plan:
- Reset, penalties {5,-4,-12,-4}, query "ACGT", target "ACGT" ID 0 → at load+5, vld[0]=1, results slot0=2068, IDs slot0=0, max={0,2068}, vld_max=1.
- Query "AAAA", target "TTTT" → result 2048. Target with length 0 → result 2048 one cycle after load.
- Query "ACGTACGT", target "ACGACGT" → result 2071 (7 matches, one gap open, score 23).
- MODULES=2, ready, five length-8 targets offered on consecutive cycles → slots 0-3 filled, full=1 after the fourth, fifth dropped; full drops when results complete; reload clears vld.
- Targets scoring 10 (ID 1) and 20 (ID 2), then 20 (ID 3) → max={2,2068} held; new query load clears vld_max.
- Assert rst=0 mid-computation → all outputs 0 immediately; after release, ready=0 until penalties and query are reloaded.
